color_bbox: RTL and testbench
=============================

// Module: color_bbox
// PURPOSE
//  Drains the camera output-buffer FIFO (RGB565, read side) in the system clock domain,
//  tags every pixel with its (x,y) position and an in-range colour-match flag, and forwards
//  it on a valid/ready stream to the display/overlay path. Accumulates a per-frame bounding
//  box and match count of matching pixels, then publishes them once per completed frame.
// PARAMETERS
//  IMG_W  640  pixels per line
//  IMG_H  480  lines per frame
//  XW     10   x coordinate width (>= clog2(IMG_W))
//  YW     9    y coordinate width (>= clog2(IMG_H))
//  CW     19   match-count width (>= clog2(IMG_W*IMG_H+1))
// PORTS
//  i_clk         in   1   system clock (FIFO read clock)
//  i_rst         in   1   synchronous reset, active-high
//  i_sof         in   1   start-of-frame pulse, already synchronised to i_clk
//  i_obuf_empty  in   1   FIFO empty flag
//  i_obuf_data   in   16  FIFO read data, valid the cycle after i_rd
//  o_obuf_rd     out  1   FIFO read enable (pop)
//  i_thr_lo      in   16  RGB565 lower bounds {R5,G6,B5}, inclusive per channel
//  i_thr_hi      in   16  RGB565 upper bounds, inclusive per channel
//  o_valid       out  1   output pixel valid
//  i_ready       in   1   downstream ready
//  o_pix         out  16  RGB565 pixel
//  o_x / o_y     out  XW/YW  pixel coordinates
//  o_match       out  1   all three channels within [lo,hi]
//  o_eol / o_eof out  1   last pixel of line / last pixel of frame
//  o_bbox_valid  out  1   1-cycle pulse: frame statistics below are new
//  o_bbox_found  out  1   at least one matching pixel in frame
//  o_xmin,o_xmax out  XW  bounding box x (0 when not found)
//  o_ymin,o_ymax out  YW  bounding box y (0 when not found)
//  o_count       out  CW  matching pixels in frame
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, skid buffer empty. Thresholds sampled live.
//  - FSM: IDLE -(i_sof)-> RUN -(pop of pixel IMG_W*IMG_H-1)-> DRAIN -(eof pixel accepted
//    downstream)-> REPORT (1 cycle, o_bbox_valid=1) -> IDLE.
//  - Pop rule: o_obuf_rd = RUN & ~i_obuf_empty & (in_flight + held < 2) & pops<IMG_W*IMG_H.
//    Never pops in IDLE/DRAIN/REPORT; extra FIFO data stays for the next frame.
//  - Latency: rd at cycle n -> data captured n+1 -> o_valid at n+2 (classification registered).
//    Sustains one pixel/cycle while i_ready=1 and FIFO non-empty.
//  - Handshake: transfer when o_valid & i_ready; o_* payload stable while o_valid & ~i_ready;
//    2-entry skid absorbs the read latency, no pixel dropped or duplicated.
//  - Coords: x increments per popped pixel, wraps IMG_W-1 -> 0 with y+1; o_eol at x=IMG_W-1,
//    o_eof at x=IMG_W-1,y=IMG_H-1.
//  - Match: R=d[15:11], G=d[10:5], B=d[4:0]; unsigned lo<=c<=hi each. lo>hi on a channel
//    -> never matches.
//  - Stats update on classification: first match loads xmin=xmax=x, ymin=ymax=y; later
//    matches min/max. Count saturates at all-ones. Latched to o_* only in REPORT; held until
//    next REPORT.
//  - i_sof in RUN/DRAIN: abort frame: stats and coords cleared, skid flushed, no o_bbox_valid,
//    re-enter RUN at (0,0). In-flight FIFO word discarded. i_sof in REPORT: pulse completes,
//    then RUN.
//  - i_rst mid-frame: immediate return to reset state next cycle; o_valid drops.
// STRUCTURE
//  - color_pkg: rgb565_t packed struct {r[4:0],g[5:0],b[4:0]}, state enum
//    {IDLE,RUN,DRAIN,REPORT}, in_range() function.
//  - Sub-module pix_skid: 2-entry valid/ready skid buffer, parameterised payload width.
//  - Top: FSM, pop control, coord counters, classifier register, stats accumulators.
// TESTING (IMG_W=4, IMG_H=2, lo=16'h0000, hi=16'hF800 unless stated)
//  1 Full frame, i_ready=1: 8 pixels, only (1,0)=F800,(2,1)=F800 -> o_valid 8 beats,
//    match on those two, o_bbox_valid once: found=1, x 1..2, y 0..1, count=2.
//  2 Backpressure: i_ready toggles 1-0-0-1 pseudo-random -> output order/payload identical to
//    test 1, no FIFO pop while skid full, payload stable under stall.
//  3 No match: all pixels 07E0 -> found=0, count=0, xmin..ymax=0, eol at x=3, eof at (3,1).
//  4 Mid-frame i_sof after 5 pixels -> no bbox pulse, next 8 pixels report coords from (0,0).
//  5 FIFO empty gaps: empty asserted every other cycle -> o_obuf_rd never asserted when empty;
//    result equal to test 1.
//  6 i_rst pulse during pixel 3 -> all outputs 0 next cycle, FSM waits for i_sof.

Source files
------------

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types and the per-channel colour window test for color_bbox.
package color_pkg;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      REPORT
   } state_t;

   // An inverted window (lo > hi) on any channel can never be satisfied.
   function automatic logic in_range(input rgb565_t p, input rgb565_t lo, input rgb565_t hi);
      return (p.r >= lo.r) && (p.r <= hi.r) &&
             (p.g >= lo.g) && (p.g <= hi.g) &&
             (p.b >= lo.b) && (p.b <= hi.b);
   endfunction

endpackage

// File: rtl/pix_skid.sv
// rtl/pix_skid.sv - 2-entry valid/ready skid buffer; the producer guarantees it never overfills.
module pix_skid #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   input  logic         i_ready,
   output logic [1:0]   o_count
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic         pop;

   assign pop     = (cnt_q != 2'd0) & i_ready;
   assign o_valid = (cnt_q != 2'd0);
   assign o_data  = head_q;
   assign o_count = cnt_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case (cnt_q)
         2'd0: begin
            if (i_valid) begin
               head_d = i_data;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (pop && i_valid) begin
               head_d = i_data;
            end else if (pop) begin
               cnt_d = 2'd0;
            end else if (i_valid) begin
               tail_d = i_data;
               cnt_d  = 2'd2;
            end
         end
         default: begin
            if (pop) begin
               head_d = tail_q;
               if (i_valid) begin
                  tail_d = i_data;
               end else begin
                  cnt_d = 2'd1;
               end
            end
         end
      endcase
      if (i_flush) begin
         cnt_d  = 2'd0;
         head_d = '0;
         tail_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/color_bbox.sv
// rtl/color_bbox.sv - drains the RGB565 output FIFO, tags pixels with coords and colour match,
// and publishes a per-frame bounding box and match count.
module color_bbox #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = 10,
   parameter int YW    = 9,
   parameter int CW    = 19
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_sof,
   input  logic          i_obuf_empty,
   input  logic [15:0]   i_obuf_data,
   output logic          o_obuf_rd,
   input  logic [15:0]   i_thr_lo,
   input  logic [15:0]   i_thr_hi,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [15:0]   o_pix,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_match,
   output logic          o_eol,
   output logic          o_eof,
   output logic          o_bbox_valid,
   output logic          o_bbox_found,
   output logic [XW-1:0] o_xmin,
   output logic [XW-1:0] o_xmax,
   output logic [YW-1:0] o_ymin,
   output logic [YW-1:0] o_ymax,
   output logic [CW-1:0] o_count
);
   import color_pkg::*;

   localparam int NPIX = IMG_W * IMG_H;
   localparam int PW   = 16 + XW + YW + 3;

   state_t        state_q, state_d;
   logic          rd_q;
   logic [CW-1:0] pops_q;
   logic [XW-1:0] x_q, xmin_q, xmax_q;
   logic [YW-1:0] y_q, ymin_q, ymax_q;
   logic          found_q;
   logic [CW-1:0] cnt_q;

   logic          bb_valid_q, bb_found_q;
   logic [XW-1:0] bb_xmin_q, bb_xmax_q;
   logic [YW-1:0] bb_ymin_q, bb_ymax_q;
   logic [CW-1:0] bb_cnt_q;

   logic [1:0]    skid_cnt, occ;
   logic [PW-1:0] skid_data;
   logic          xfer, abort, clear, cap, match_c, eol_c, eof_c;

   assign xfer  = o_valid & i_ready;
   assign abort = i_sof & ((state_q == RUN) | (state_q == DRAIN));
   assign clear = i_sof | (state_q == REPORT);
   assign cap   = rd_q & ~abort;

   // Words already committed after this cycle's output transfer: the one in flight plus skid contents.
   assign occ = 2'(rd_q) + skid_cnt - 2'(xfer);
   assign o_obuf_rd = (state_q == RUN) & ~i_obuf_empty & ~i_sof & ~i_rst &
                      (occ < 2'd2) & (pops_q < CW'(NPIX));

   assign match_c = in_range(rgb565_t'(i_obuf_data), rgb565_t'(i_thr_lo), rgb565_t'(i_thr_hi));
   assign eol_c   = (x_q == XW'(IMG_W - 1));
   assign eof_c   = eol_c & (y_q == YW'(IMG_H - 1));

   pix_skid #(.W(PW)) u_skid (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (abort),
      .i_valid (cap),
      .i_data  ({i_obuf_data, x_q, y_q, match_c, eol_c, eof_c}),
      .o_valid (o_valid),
      .o_data  (skid_data),
      .i_ready (i_ready),
      .o_count (skid_cnt)
   );

   assign {o_pix, o_x, o_y, o_match, o_eol, o_eof} = skid_data;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_sof) state_d = RUN;
         RUN: begin
            if (!abort && o_obuf_rd && (pops_q == CW'(NPIX - 1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (abort) state_d = RUN;
            else if (xfer && o_eof) state_d = REPORT;
         end
         default: state_d = i_sof ? RUN : IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         rd_q       <= 1'b0;
         pops_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         found_q    <= 1'b0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymin_q     <= '0;
         ymax_q     <= '0;
         cnt_q      <= '0;
         bb_valid_q <= 1'b0;
         bb_found_q <= 1'b0;
         bb_xmin_q  <= '0;
         bb_xmax_q  <= '0;
         bb_ymin_q  <= '0;
         bb_ymax_q  <= '0;
         bb_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         bb_valid_q <= 1'b0;
         if ((state_q == DRAIN) && (state_d == REPORT)) begin
            bb_valid_q <= 1'b1;
            bb_found_q <= found_q;
            bb_xmin_q  <= xmin_q;
            bb_xmax_q  <= xmax_q;
            bb_ymin_q  <= ymin_q;
            bb_ymax_q  <= ymax_q;
            bb_cnt_q   <= cnt_q;
         end
         if (clear) begin
            rd_q    <= 1'b0;
            pops_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cnt_q   <= '0;
         end else begin
            rd_q <= o_obuf_rd;
            if (o_obuf_rd) pops_q <= pops_q + 1'b1;
            if (cap) begin
               if (eol_c) begin
                  x_q <= '0;
                  y_q <= y_q + 1'b1;
               end else begin
                  x_q <= x_q + 1'b1;
               end
               if (match_c) begin
                  found_q <= 1'b1;
                  if (!found_q) begin
                     xmin_q <= x_q;
                     xmax_q <= x_q;
                     ymin_q <= y_q;
                     ymax_q <= y_q;
                  end else begin
                     if (x_q < xmin_q) xmin_q <= x_q;
                     if (x_q > xmax_q) xmax_q <= x_q;
                     if (y_q < ymin_q) ymin_q <= y_q;
                     if (y_q > ymax_q) ymax_q <= y_q;
                  end
                  if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign o_bbox_valid = bb_valid_q;
   assign o_bbox_found = bb_found_q;
   assign o_xmin       = bb_xmin_q;
   assign o_xmax       = bb_xmax_q;
   assign o_ymin       = bb_ymin_q;
   assign o_ymax       = bb_ymax_q;
   assign o_count      = bb_cnt_q;

endmodule

// File: tb/tb_color_bbox.sv
// tb/tb_color_bbox.sv - scoreboard bench for color_bbox on a 4x2 frame with a modelled FIFO.
module tb_color_bbox;
   localparam int W = 4, H = 2, N = W * H, XW = 10, YW = 9, CW = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          i_rst, i_sof, i_obuf_empty, o_obuf_rd, o_valid, i_ready;
   logic          o_match, o_eol, o_eof, o_bbox_valid, o_bbox_found;
   logic [15:0]   i_obuf_data, i_thr_lo, i_thr_hi, o_pix;
   logic [XW-1:0] o_x, o_xmin, o_xmax;
   logic [YW-1:0] o_y, o_ymin, o_ymax;
   logic [CW-1:0] o_count;

   typedef struct packed {
      logic [15:0] pix; logic [XW-1:0] x; logic [YW-1:0] y; logic m; logic eol; logic eof;
   } beat_t;
   typedef struct packed {
      logic found; logic [XW-1:0] xmin; logic [XW-1:0] xmax;
      logic [YW-1:0] ymin; logic [YW-1:0] ymax; logic [CW-1:0] cnt;
   } bbox_t;

   beat_t       exp_q[$];
   bbox_t       bb_q[$];
   logic [15:0] fifo_q[$];
   logic [15:0] frame_w[N];
   logic [15:0] t1_w[N];
   int          checks = 0, errors = 0, pop_cnt = 0, xfer_cnt = 0;
   bit          gap_mode = 1'b0, rand_ready = 1'b0, gap_t = 1'b0;
   logic        rd_s;

   color_bbox #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .CW(CW)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_sof(i_sof), .i_obuf_empty(i_obuf_empty),
      .i_obuf_data(i_obuf_data), .o_obuf_rd(o_obuf_rd), .i_thr_lo(i_thr_lo), .i_thr_hi(i_thr_hi),
      .o_valid(o_valid), .i_ready(i_ready), .o_pix(o_pix), .o_x(o_x), .o_y(o_y),
      .o_match(o_match), .o_eol(o_eol), .o_eof(o_eof), .o_bbox_valid(o_bbox_valid),
      .o_bbox_found(o_bbox_found), .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin),
      .o_ymax(o_ymax), .o_count(o_count)
   );

   function automatic bit ref_match(input logic [15:0] p, input logic [15:0] lo, input logic [15:0] hi);
      return (p[15:11] >= lo[15:11]) && (p[15:11] <= hi[15:11]) &&
             (p[10:5]  >= lo[10:5])  && (p[10:5]  <= hi[10:5])  &&
             (p[4:0]   >= lo[4:0])   && (p[4:0]   <= hi[4:0]);
   endfunction

   // Pixel i of a frame sits at (i mod W, i div W); the box is min/max over matching positions.
   task automatic issue(input int n, input bit complete);
      beat_t b;
      bbox_t bb;
      bb = '0;
      for (int i = 0; i < n; i++) begin
         b.pix = frame_w[i];
         b.x   = XW'(i % W);
         b.y   = YW'(i / W);
         b.m   = ref_match(frame_w[i], i_thr_lo, i_thr_hi);
         b.eol = ((i % W) == W - 1);
         b.eof = (i == N - 1);
         exp_q.push_back(b);
         fifo_q.push_back(frame_w[i]);
         if (b.m) begin
            if (!bb.found) begin
               bb.found = 1'b1;
               bb.xmin = b.x; bb.xmax = b.x; bb.ymin = b.y; bb.ymax = b.y;
            end else begin
               if (b.x < bb.xmin) bb.xmin = b.x;
               if (b.x > bb.xmax) bb.xmax = b.x;
               if (b.y < bb.ymin) bb.ymin = b.y;
               if (b.y > bb.ymax) bb.ymax = b.y;
            end
            bb.cnt = bb.cnt + 1'b1;
         end
      end
      if (complete) bb_q.push_back(bb);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_sof();
      i_sof = 1'b1;
      tick(1);
      i_sof = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || bb_q.size() != 0) && c < 500) begin
         tick(1);
         c++;
      end
      checks++;
      if (exp_q.size() != 0 || bb_q.size() != 0) begin
         errors++;
         $display("FAIL %s timeout: %0d beats and %0d reports outstanding, want 0",
                  name, exp_q.size(), bb_q.size());
         exp_q.delete(); bb_q.delete(); fifo_q.delete();
      end
      tick(3);
   endtask

   task automatic do_reset(input string name);
      i_rst = 1'b1;
      exp_q.delete(); bb_q.delete(); fifo_q.delete();
      pop_cnt = 0; xfer_cnt = 0;
      tick(1);
      checks++;
      if ({o_valid, o_obuf_rd, o_bbox_valid, o_bbox_found, o_pix, o_x, o_y, o_match, o_eol, o_eof,
           o_xmin, o_xmax, o_ymin, o_ymax, o_count} !== '0) begin
         errors++;
         $display("FAIL %s outputs: valid=%b rd=%b bbv=%b pix=%h x=%0d y=%0d count=%0d, want all 0",
                  name, o_valid, o_obuf_rd, o_bbox_valid, o_pix, o_x, o_y, o_count);
      end
      i_rst = 1'b0;
      tick(1);
   endtask

   // FIFO read side: data for a pop appears the cycle after o_obuf_rd.
   initial begin
      i_obuf_empty = 1'b1;
      i_obuf_data  = '0;
      forever begin
         @(negedge clk);
         rd_s = o_obuf_rd;
         @(posedge clk);
         #1;
         if (rd_s && fifo_q.size() != 0) begin
            i_obuf_data = fifo_q.pop_front();
            pop_cnt++;
         end
         gap_t = ~gap_t;
         i_obuf_empty = (fifo_q.size() == 0) || (gap_mode && gap_t);
      end
   end

   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   beat_t got, prev_got;
   bbox_t got_bb, want_bb;
   bit    stall_prev = 1'b0;
   beat_t want;

   always @(negedge clk) begin
      got = {o_pix, o_x, o_y, o_match, o_eol, o_eof};
      if (i_rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!o_valid || got != prev_got) begin
               errors++;
               $display("FAIL stall_hold: valid=%b pix=%h x=%0d y=%0d, want valid=1 pix=%h x=%0d y=%0d",
                        o_valid, got.pix, got.x, got.y, prev_got.pix, prev_got.x, prev_got.y);
            end
         end
         if (o_obuf_rd) begin
            checks++;
            if (i_obuf_empty) begin
               errors++;
               $display("FAIL rd_when_empty: o_obuf_rd=1 with empty=1, want rd=0");
            end
            checks++;
            if (pop_cnt - xfer_cnt - int'(o_valid && i_ready) + 1 > 2) begin
               errors++;
               $display("FAIL rd_skid_full: %0d words outstanding after pop, want <= 2",
                        pop_cnt - xfer_cnt - int'(o_valid && i_ready) + 1);
            end
         end
         if (o_valid && i_ready) begin
            checks++;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_extra: got pix=%h x=%0d y=%0d, want no beat", got.pix, got.x, got.y);
            end else begin
               want = exp_q.pop_front();
               if (got != want) begin
                  errors++;
                  $display("FAIL beat: got pix=%h x=%0d y=%0d m=%b eol=%b eof=%b, want pix=%h x=%0d y=%0d m=%b eol=%b eof=%b",
                           got.pix, got.x, got.y, got.m, got.eol, got.eof,
                           want.pix, want.x, want.y, want.m, want.eol, want.eof);
               end
            end
         end
         stall_prev = o_valid && !i_ready;
         prev_got   = got;
         if (o_bbox_valid) begin
            checks++;
            got_bb = {o_bbox_found, o_xmin, o_xmax, o_ymin, o_ymax, o_count};
            if (bb_q.size() == 0) begin
               errors++;
               $display("FAIL bbox_extra: got found=%b count=%0d, want no pulse", o_bbox_found, o_count);
            end else begin
               want_bb = bb_q.pop_front();
               if (got_bb != want_bb) begin
                  errors++;
                  $display("FAIL bbox: got f=%b x=%0d..%0d y=%0d..%0d n=%0d, want f=%b x=%0d..%0d y=%0d..%0d n=%0d",
                           got_bb.found, got_bb.xmin, got_bb.xmax, got_bb.ymin, got_bb.ymax, got_bb.cnt,
                           want_bb.found, want_bb.xmin, want_bb.xmax, want_bb.ymin, want_bb.ymax, want_bb.cnt);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   logic [15:0] a, b, lo, hi;

   initial begin
      i_rst = 1'b1; i_sof = 1'b0;
      i_thr_lo = 16'h0000; i_thr_hi = 16'hF800;
      tick(2);
      do_reset("reset");

      for (int i = 0; i < N; i++) t1_w[i] = 16'($urandom) | 16'h0020;
      t1_w[1] = 16'hF800;
      t1_w[6] = 16'hF800;

      frame_w = t1_w; issue(N, 1'b1); pulse_sof(); wait_done("full_frame");

      rand_ready = 1'b1;
      frame_w = t1_w; issue(N, 1'b1); pulse_sof(); wait_done("backpressure");

      for (int i = 0; i < N; i++) frame_w[i] = 16'h07E0;
      issue(N, 1'b1); pulse_sof(); wait_done("no_match");
      rand_ready = 1'b0;

      for (int i = 0; i < N; i++) frame_w[i] = ($urandom_range(0, 2) == 0) ? 16'hF800 : 16'($urandom);
      issue(5, 1'b0); pulse_sof(); wait_done("abort_part");
      pulse_sof();
      for (int i = 0; i < N; i++) frame_w[i] = ($urandom_range(0, 2) == 0) ? 16'hF800 : 16'($urandom);
      issue(N, 1'b1); wait_done("abort_restart");

      gap_mode = 1'b1;
      frame_w = t1_w; issue(N, 1'b1); pulse_sof(); wait_done("empty_gaps");
      gap_mode = 1'b0;

      frame_w = t1_w; issue(N, 1'b1); pulse_sof();
      for (int c = 0; c < 100 && exp_q.size() > N - 3; c++) tick(1);
      do_reset("mid_reset");
      frame_w = t1_w; issue(N, 1'b1);
      tick(10);
      checks++;
      if (pop_cnt != 0) begin
         errors++;
         $display("FAIL idle_no_pop: %0d pops before sof, want 0", pop_cnt);
      end
      pulse_sof(); wait_done("after_reset");

      for (int f = 0; f < 6; f++) begin
         a = 16'($urandom); b = 16'($urandom);
         lo = a; hi = b;
         if (f < 4) begin
            lo = {(a[15:11] < b[15:11]) ? a[15:11] : b[15:11],
                  (a[10:5]  < b[10:5])  ? a[10:5]  : b[10:5],
                  (a[4:0]   < b[4:0])   ? a[4:0]   : b[4:0]};
            hi = {(a[15:11] < b[15:11]) ? b[15:11] : a[15:11],
                  (a[10:5]  < b[10:5])  ? b[10:5]  : a[10:5],
                  (a[4:0]   < b[4:0])   ? b[4:0]   : a[4:0]};
         end
         if (f == 4) begin
            lo[10:5] = 6'd40;
            hi[10:5] = 6'd10;
         end
         i_thr_lo = lo; i_thr_hi = hi;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1)
               frame_w[i] = {5'($urandom_range(lo[15:11], hi[15:11])),
                             6'($urandom_range(lo[10:5], hi[10:5])),
                             5'($urandom_range(lo[4:0], hi[4:0]))};
            else
               frame_w[i] = 16'($urandom);
         end
         rand_ready = f[0];
         gap_mode   = f[1];
         issue(N, 1'b1); pulse_sof(); wait_done("random_frame");
      end
      rand_ready = 1'b0; gap_mode = 1'b0;
      tick(5);

      checks++;
      if (exp_q.size() != 0 || bb_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d beats %0d reports, want 0", exp_q.size(), bb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
